// File: rtl/spi_port_pkg.sv
// Shared definitions for the SPI gateway FIFO port: status byte layout,
// flag bit positions and the decoded bus-target type.
package spi_port_pkg;

  localparam logic [1:0] STAT_IDX_TX_LEVEL = 2'd0;
  localparam logic [1:0] STAT_IDX_RX_FREE  = 2'd1;
  localparam logic [1:0] STAT_IDX_FLAGS    = 2'd2;

  localparam logic [2:0] FLAG_BIT_RX_OVF = 3'd1;
  localparam logic [2:0] FLAG_BIT_TX_UNF = 3'd0;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_WR,
    PORT_RD,
    PORT_STAT
  } port_sel_e;

  function automatic logic [7:0] flag_byte(input logic rx_ovf, input logic tx_unf);
    logic [7:0] b;
    b = '0;
    b[FLAG_BIT_RX_OVF] = rx_ovf;
    b[FLAG_BIT_TX_UNF] = tx_unf;
    return b;
  endfunction

  function automatic logic [7:0] status_byte(input logic [1:0] idx,
                                             input logic [7:0] tx_level,
                                             input logic [7:0] rx_free,
                                             input logic [7:0] flags);
    case (idx)
      STAT_IDX_TX_LEVEL: return tx_level;
      STAT_IDX_RX_FREE:  return rx_free;
      STAT_IDX_FLAGS:    return flags;
      default:           return '0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through head, full/empty
// flags and an occupancy count one bit wider than the pointers.
module sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push+pop at full is a pass-through.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_fifo_port.sv
// SPI gateway bus port exposing an RX FIFO (host writes), a TX FIFO (host
// reads) and a status register; TX pops commit only on a shifted-out byte.
module spi_fifo_port
  import spi_port_pkg::*;
#(
  parameter logic [7:0]  ADDR_WR    = 8'h10,
  parameter logic [7:0]  ADDR_RD    = 8'h11,
  parameter logic [7:0]  ADDR_STAT  = 8'h12,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RXD,
  input  logic [7:0] ADDR,
  input  logic       SEL,
  input  logic       TXE,
  input  logic       RXE,
  output logic [7:0] TXD,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_OVF,
  output logic       TX_UNF
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  port_sel_e port;
  logic      txe_q;
  logic      txe_rise;
  logic [7:0] tx_byte;
  logic      pend;
  logic [1:0] bidx;
  logic      rx_ovf_q;
  logic      tx_unf_q;

  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [LW-1:0] rx_level;
  logic [7:0]    rx_head;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [LW-1:0] tx_level;
  logic [7:0]    tx_head;

  logic [7:0] rx_free;
  logic [7:0] tx_level8;
  logic       rx_ovf_set;
  logic       tx_unf_set;
  logic       flag_clr;

  always_comb begin
    port = PORT_NONE;
    if (SEL) begin
      if (ADDR == ADDR_WR) begin
        port = PORT_WR;
      end else if (ADDR == ADDR_RD) begin
        port = PORT_RD;
      end else if (ADDR == ADDR_STAT) begin
        port = PORT_STAT;
      end
    end
  end

  assign txe_rise  = TXE & ~txe_q;
  assign TXD       = (TXE && port != PORT_NONE) ? tx_byte : 'z;

  assign rx_free   = 8'(LW'(DEPTH) - rx_level);
  assign tx_level8 = 8'(tx_level);

  // RX fullness is taken before the fabric pop, so a same-cycle pop never makes room.
  assign rx_push    = RXE & (port == PORT_WR) & ~rx_full;
  assign rx_ovf_set = RXE & (port == PORT_WR) & rx_full;
  assign rx_pop     = ~rx_empty & RX_READY;

  assign tx_push    = TX_VALID & ~tx_full;
  assign tx_pop     = RXE & (port == PORT_RD) & pend;
  assign tx_unf_set = RXE & (port == PORT_RD) & ~pend;

  assign flag_clr   = RXE & (port == PORT_STAT) & (bidx == STAT_IDX_FLAGS);

  assign TX_READY = ~tx_full;
  assign RX_VALID = ~rx_empty;
  assign RX_DATA  = rx_head;
  assign RX_OVF   = rx_ovf_q;
  assign TX_UNF   = tx_unf_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      txe_q    <= 1'b0;
      tx_byte  <= '0;
      pend     <= 1'b0;
      bidx     <= '0;
      rx_ovf_q <= 1'b0;
      tx_unf_q <= 1'b0;
    end else begin
      txe_q <= TXE;

      if (txe_rise) begin
        case (port)
          PORT_WR:   tx_byte <= rx_free;
          PORT_RD:   tx_byte <= tx_empty ? 8'h00 : tx_head;
          PORT_STAT: tx_byte <= status_byte(bidx, tx_level8, rx_free,
                                            flag_byte(rx_ovf_q, tx_unf_q));
          default:   tx_byte <= tx_byte;
        endcase
      end

      // pend marks a preloaded head that only a following RXE may consume.
      if (!SEL) begin
        pend <= 1'b0;
      end else if (txe_rise && port == PORT_RD) begin
        pend <= ~tx_empty;
      end else if (tx_pop) begin
        pend <= 1'b0;
      end

      if (!SEL) begin
        bidx <= '0;
      end else if (RXE && bidx != 2'd3) begin
        bidx <= bidx + 1'b1;
      end

      if (rx_ovf_set) begin
        rx_ovf_q <= 1'b1;
      end else if (flag_clr) begin
        rx_ovf_q <= 1'b0;
      end

      if (tx_unf_set) begin
        tx_unf_q <= 1'b1;
      end else if (flag_clr) begin
        tx_unf_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_rx_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (rx_push),
    .push_data (RXD),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_tx_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (tx_push),
    .push_data (TX_DATA),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

endmodule

// File: tb/tb_spi_fifo_port.sv
// Bench for spi_fifo_port: directed frames from the usage scenarios plus random
// host frames and fabric traffic, checked against a queue-based model.
module tb_spi_fifo_port;

  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 1 << DL2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxd, addr, tx_data;
  logic       sel, txe, rxe, tx_valid, rx_ready;
  wire  [7:0] txd;
  wire        tx_ready, rx_valid, rx_ovf, tx_unf;
  wire  [7:0] rx_data;

  always #5 clk = ~clk;

  spi_fifo_port #(
    .ADDR_WR    (8'h10),
    .ADDR_RD    (8'h11),
    .ADDR_STAT  (8'h12),
    .DEPTH_LOG2 (DL2)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RXD      (rxd),
    .ADDR     (addr),
    .SEL      (sel),
    .TXE      (txe),
    .RXE      (rxe),
    .TXD      (txd),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .RX_OVF   (rx_ovf),
    .TX_UNF   (tx_unf)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_ovf, m_unf, m_pend;
  int unsigned m_bidx;
  logic [7:0]  cur_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_fabric();
    logic [7:0] exp_head;
    exp_head = 8'h00;
    if (m_rx.size() != 0) exp_head = m_rx[0];
    check_val("rx_valid", rx_valid, m_rx.size() != 0);
    check_val("rx_data", rx_data, exp_head);
    check_val("tx_ready", tx_ready, m_tx.size() < DEPTH);
    check_val("rx_ovf", rx_ovf, m_ovf);
    check_val("tx_unf", tx_unf, m_unf);
  endtask

  function automatic logic [7:0] model_preload();
    logic [7:0] v;
    v = 8'h00;
    case (cur_addr)
      8'h10: v = 8'(DEPTH - m_rx.size());
      8'h11: if (m_tx.size() != 0) v = m_tx[0];
      8'h12: begin
        case (m_bidx)
          0:       v = 8'(m_tx.size());
          1:       v = 8'(DEPTH - m_rx.size());
          2:       v = {6'b0, m_ovf, m_unf};
          default: v = 8'h00;
        endcase
      end
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_tx.delete();
    m_rx.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_pend = 1'b0;
    m_bidx = 0;
  endtask

  task automatic fabric_cycle(input logic push, input logic [7:0] d, input logic pop);
    check_fabric();
    tx_valid = push;
    tx_data  = d;
    rx_ready = pop;
    @(posedge clk); #1;
    if (push && m_tx.size() < DEPTH) m_tx.push_back(d);
    if (pop && m_rx.size() != 0) void'(m_rx.pop_front());
    tx_valid = 1'b0;
    rx_ready = 1'b0;
  endtask

  task automatic frame_begin(input logic [7:0] a);
    sel      = 1'b1;
    addr     = a;
    cur_addr = a;
    @(posedge clk); #1;
  endtask

  task automatic frame_end();
    sel = 1'b0;
    @(posedge clk); #1;
    m_pend = 1'b0;
    m_bidx = 0;
  endtask

  // One byte slot: two TXE cycles, then an RXE cycle.
  task automatic host_slot(input logic do_txe, input logic do_rxe, input logic [7:0] mosi,
                           input logic inj_push, input logic [7:0] push_byte, input logic inj_pop);
    logic [7:0] exp;
    logic       rx_had;
    string      tag;
    exp = 8'h00;
    txe = do_txe;
    @(posedge clk); #1;
    if (do_txe) begin
      exp = model_preload();
      if (cur_addr == 8'h11) m_pend = (m_tx.size() != 0);
    end
    if (inj_push) begin
      tx_valid = 1'b1;
      tx_data  = push_byte;
    end
    if (do_txe && cur_addr >= 8'h10 && cur_addr <= 8'h12) begin
      tag = (cur_addr == 8'h10) ? "miso_wr" : (cur_addr == 8'h11) ? "miso_rd" : "miso_stat";
      check_val(tag, txd, exp);
    end
    @(posedge clk); #1;
    if (inj_push && m_tx.size() < DEPTH) m_tx.push_back(push_byte);
    tx_valid = 1'b0;
    txe      = 1'b0;
    rxe      = do_rxe;
    rxd      = mosi;
    rx_ready = inj_pop;
    rx_had   = (m_rx.size() != 0);
    if (inj_pop && rx_had) check_val("rx_pop_data", rx_data, m_rx[0]);
    @(posedge clk); #1;
    if (do_rxe) begin
      case (cur_addr)
        8'h10: if (m_rx.size() == DEPTH) m_ovf = 1'b1; else m_rx.push_back(mosi);
        8'h11: begin
          if (m_pend) void'(m_tx.pop_front());
          else m_unf = 1'b1;
          m_pend = 1'b0;
        end
        8'h12: if (m_bidx == 2) begin m_ovf = 1'b0; m_unf = 1'b0; end
        default: ;
      endcase
      if (m_bidx < 3) m_bidx++;
    end
    if (inj_pop && rx_had) void'(m_rx.pop_front());
    rxe      = 1'b0;
    rx_ready = 1'b0;
    check_fabric();
  endtask

  initial begin
    logic [7:0]  a;
    int unsigned n;
    rst = 1'b0; sel = 1'b0; txe = 1'b0; rxe = 1'b0; rxd = '0; addr = '0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; cur_addr = '0;
    @(posedge clk); #1;
    do_reset();
    check_fabric();

    // Read stream: A1, A2 shifted out; trailing preload of A3 not popped
    fabric_cycle(1'b1, 8'hA1, 1'b0);
    fabric_cycle(1'b1, 8'hA2, 1'b0);
    fabric_cycle(1'b1, 8'hA3, 1'b0);
    frame_begin(8'h11);
    host_slot(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    host_slot(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    host_slot(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    frame_end();
    check_val("tx_left_after_frame", m_tx.size(), 1);
    frame_begin(8'h12);
    host_slot(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    frame_end();

    // Underflow: empty TX, push of 55 lands inside the TXE window
    do_reset();
    frame_begin(8'h11);
    host_slot(1'b1, 1'b1, 8'h00, 1'b1, 8'h55, 1'b0);
    frame_end();
    check_val("unf_flag_direct", tx_unf, 1);
    frame_begin(8'h12);
    host_slot(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    frame_end();

    // Overflow: DEPTH+1 writes, last one with a same-cycle fabric pop
    do_reset();
    frame_begin(8'h10);
    for (int i = 0; i < int'(DEPTH) + 1; i++)
      host_slot(1'b1, 1'b1, 8'(i + 1), 1'b0, 8'h00, i == int'(DEPTH));
    frame_end();
    check_val("ovf_flag_direct", rx_ovf, 1);

    // Status: 3 in TX, 3 in RX, RX_OVF set -> 03, 0D, 02; flags clear after
    for (int i = 0; i < int'(DEPTH) - 4; i++) fabric_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) fabric_cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    frame_begin(8'h12);
    for (int i = 0; i < 3; i++) host_slot(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    frame_end();
    frame_begin(8'h12);
    for (int i = 0; i < 3; i++) host_slot(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    frame_end();

    // Reset in the middle of a read frame with a pending preload
    frame_begin(8'h11);
    host_slot(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    do_reset();
    host_slot(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    frame_end();
    frame_begin(8'h12);
    host_slot(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    frame_end();

    // Random frames interleaved with fabric traffic
    for (int f = 0; f < 200; f++) begin
      a = 8'h10 + 8'($urandom_range(0, 3));
      n = $urandom_range(1, 6);
      repeat ($urandom_range(0, 4))
        fabric_cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0);
      frame_begin(a);
      for (int s = 0; s < int'(n); s++)
        host_slot($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 8'($urandom),
                  $urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 4) == 0);
      frame_end();
      if ($urandom_range(0, 50) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
